// File: rtl/mcb_write_gen_if.sv
// Write-generator bus: run control, write-FIFO data path, MCB command channel and status.
// The generator drives through the master modport; the memory side and test stimulus use slave.
interface mcb_write_gen_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 30
);
  logic              start;
  logic [1:0]        mode;
  logic              wr_rdy;
  logic              cmd_done;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              cmd_en;
  logic [ADDR_W-1:0] cmd_addr;
  logic [6:0]        cmd_len;
  logic              busy;
  logic [31:0]       burst_cnt;
  logic              wrap;

  modport master (
    input  start, mode, wr_rdy, cmd_done,
    output wr_en, wr_data, cmd_en, cmd_addr, cmd_len, busy, burst_cnt, wrap
  );

  modport slave (
    output start, mode, wr_rdy, cmd_done,
    input  wr_en, wr_data, cmd_en, cmd_addr, cmd_len, busy, burst_cnt, wrap
  );
endinterface

// File: rtl/mcb_write_gen.sv
// MCB write traffic generator: bursts of patterned beats plus one command per burst.
// Define MCB_WR_PRBS_EN to build the LFSR pattern for mode 11 (otherwise mode 11 = alternating).
module mcb_write_gen #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned CMD_THRESH = 40,
  parameter int unsigned ADDR_INC   = 'h400,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 'h10000000 - 'h400
) (
  input  logic           clk,
  input  logic           rst,
  mcb_write_gen_if.master bus
);
  localparam int unsigned LANES = DATA_W / 32;
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned THR   = (CMD_THRESH > BURST_LEN) ? BURST_LEN : CMD_THRESH;
  localparam logic [6:0]  BL7   = 7'(BURST_LEN);
  localparam logic [6:0]  THR7  = 7'(THR);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;
  typedef enum logic [1:0] {M_ALT = 2'b00, M_CNT = 2'b01, M_ADR = 2'b10, M_PRBS = 2'b11} mode_e;

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d, mode_eff_c;
  logic [6:0]          beat_q, beat_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         burst_cnt_q, burst_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic                cmd_en_q, cmd_en_d;
  logic                issued_q, issued_d;
  logic                done_q, done_d;
  logic                wrap_q, wrap_d;
  logic                busy_q, busy_d;
  logic                accept_c, start_burst_c, complete_c;
  logic [31:0]         lfsr_d;

  assign accept_c = wr_en_q & bus.wr_rdy;

`ifdef MCB_WR_PRBS_EN
  logic [31:0] lfsr_q;

  // Fibonacci LFSR x^32+x^22+x^2+x+1, one step per accepted beat
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 32'h1;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_d     = accept_c ? {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]}
                               : lfsr_q;
  assign mode_eff_c = mode_e'(bus.mode);
`else
  assign lfsr_d     = 32'h1;
  assign mode_eff_c = (bus.mode == 2'b11) ? M_ALT : mode_e'(bus.mode);
`endif

  function automatic logic [DATA_W-1:0] lanes(input logic [31:0] v);
    return {LANES{v}};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= M_ALT;
      beat_q      <= '0;
      cnt_q       <= '0;
      data_q      <= {BYTES{8'hAA}};
      addr_q      <= ADDR_W'(START_ADDR);
      burst_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      cmd_en_q    <= 1'b0;
      issued_q    <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      burst_cnt_q <= burst_cnt_d;
      wr_en_q     <= wr_en_d;
      cmd_en_q    <= cmd_en_d;
      issued_q    <= issued_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    beat_d        = beat_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    addr_d        = addr_q;
    burst_cnt_d   = burst_cnt_q;
    cmd_en_d      = cmd_en_q;
    issued_d      = issued_q;
    done_d        = done_q;
    wrap_d        = 1'b0;
    start_burst_c = 1'b0;
    complete_c    = 1'b0;

    if (accept_c) begin
      beat_d = beat_q + 7'd1;
      cnt_d  = cnt_q + 32'd1;
      case (mode_q)
        M_ALT:   data_d = ~data_q;
        M_CNT:   data_d = lanes(cnt_d);
        M_ADR:   data_d = lanes(32'(addr_q) + 32'(beat_d));
        default: data_d = lanes(lfsr_d);
      endcase
      if (!issued_q && beat_d == THR7) begin
        cmd_en_d = 1'b1;
        issued_d = 1'b1;
      end
    end

    // cmd_done only counts while a command is outstanding
    if (cmd_en_q && bus.cmd_done) begin
      cmd_en_d = 1'b0;
      done_d   = 1'b1;
    end

    case (state_q)
      IDLE:  if (bus.start) start_burst_c = 1'b1;
      LOAD:  if (beat_d == BL7) begin
               if (done_d) complete_c = 1'b1;
               else        state_d    = DRAIN;
             end
      DRAIN: if (done_d) complete_c = 1'b1;
      default: state_d = IDLE;
    endcase

    if (complete_c) begin
      burst_cnt_d = burst_cnt_q + 32'd1;
      beat_d      = '0;
      done_d      = 1'b0;
      issued_d    = 1'b0;
      if (addr_q >= ADDR_W'(END_ADDR)) begin
        addr_d = ADDR_W'(START_ADDR);
        wrap_d = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_W'(ADDR_INC);
      end
      if (bus.start) start_burst_c = 1'b1;
      else           state_d       = IDLE;
    end

    // New burst: latch the pattern mode and load the first beat
    if (start_burst_c) begin
      state_d = LOAD;
      mode_d  = mode_eff_c;
      case (mode_eff_c)
        M_ALT:   data_d = {BYTES{8'hAA}};
        M_CNT:   data_d = lanes(cnt_d);
        M_ADR:   data_d = lanes(32'(addr_d));
        default: data_d = lanes(lfsr_d);
      endcase
    end

    wr_en_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = data_q;
  assign bus.cmd_en    = cmd_en_q;
  assign bus.cmd_addr  = addr_q;
  assign bus.cmd_len   = BL7;
  assign bus.busy      = busy_q;
  assign bus.burst_cnt = burst_cnt_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: doc/mcb_write_gen.md
MCB_WRITE_GEN -- requirements
Module: mcb_write_gen

Interface
Parameters:
REQ-001 SHALL have parameter DATA_W, default 128, meaning write data width in bits; must be a multiple of 32.
REQ-002 SHALL have parameter ADDR_W, default 30, meaning command byte-address width.
REQ-003 SHALL have parameter BURST_LEN, default 64, meaning data beats per burst (1..127).
REQ-004 SHALL have parameter CMD_THRESH, default 40, meaning the accepted-beat count at which cmd_en asserts; values above BURST_LEN clamp to BURST_LEN.
REQ-005 SHALL have parameter ADDR_INC, default 'h400, meaning address step per burst.
REQ-006 SHALL have parameter START_ADDR, default 0, meaning first and wrap-target address.
REQ-007 SHALL have parameter END_ADDR, default 'h10000000-'h400, meaning last burst address before wrap.

Ports:
REQ-008 SHALL provide these ports:
- clk  in  1  single clock; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- start  in  1  level run enable.
- mode  in  2  data pattern: 00 alternating, 01 counter, 10 address-tagged, 11 PRBS.
- wr_rdy  in  1  write FIFO accepts a beat this cycle.
- cmd_done  in  1  MCB accepted the command.
- wr_en  out  1  beat valid.
- wr_data  out  DATA_W  beat data.
- cmd_en  out  1  command request.
- cmd_addr  out  ADDR_W  burst address.
- cmd_len  out  7  burst length, equal to BURST_LEN.
- busy  out  1  high whenever the state is not IDLE.
- burst_cnt  out  32  completed bursts, wrapping modulo 2^32.
- wrap  out  1  one-cycle pulse on address wrap.

Function
REQ-009 A beat SHALL be accepted only on a cycle with wr_en=1 and wr_rdy=1; no data change SHALL occur otherwise.
REQ-010 The state machine SHALL have three states:
- IDLE: leaves to LOAD when start=1.
- LOAD: wr_en=1; moves to DRAIN after beat BURST_LEN is accepted.
- DRAIN: wr_en=0; waits for the burst to complete.
REQ-011 A burst SHALL be complete when all BURST_LEN beats are accepted and cmd_done has been seen for that burst; order is either, and both may fall in the same cycle.
REQ-012 On completion the block SHALL return to LOAD if start=1, otherwise to IDLE, with no idle cycle in between.
REQ-013 cmd_en SHALL rise the cycle after the accepted-beat count reaches CMD_THRESH, SHALL stay high until cmd_done, and SHALL drop the cycle after cmd_done.
REQ-014 cmd_done SHALL be ignored while cmd_en=0.
REQ-015 cmd_addr and cmd_len SHALL stay stable from LOAD entry until burst completion.
REQ-016 mode SHALL be sampled only on the IDLE->LOAD transition and on burst-to-burst transitions.
REQ-017 Alternating mode: the first beat of each burst SHALL be all bytes 8'hAA, and each accepted beat SHALL invert the data.
REQ-018 Counter mode: every 32-bit lane SHALL hold a 32-bit running beat count; the count starts at 0 after reset and never clears per burst.
REQ-019 Address-tagged mode: lane i SHALL hold cmd_addr[31:0] + beat index, with the beat index starting at 0 each burst and additions modulo 2^32.
REQ-020 Address update on completion: if cmd_addr >= END_ADDR, the next cmd_addr SHALL be START_ADDR and wrap SHALL pulse for one cycle; otherwise the next cmd_addr SHALL be cmd_addr + ADDR_INC, truncated to ADDR_W bits.
REQ-021 burst_cnt SHALL increment by 1 on each completion.
REQ-022 start dropping mid-burst SHALL NOT abort the burst; the block SHALL finish it and then go to IDLE.

Reset
REQ-023 With rst=1 at a clk edge, the block SHALL go to IDLE with:
- wr_en=0, cmd_en=0, wrap=0, busy=0
- cmd_addr=START_ADDR, cmd_len=BURST_LEN
- wr_data all bytes 8'hAA
- burst_cnt=0, beat counters 0, LFSR=32'h1
REQ-024 Reset SHALL take effect mid-burst with no completion side effects; the partial burst is discarded.

Configuration
REQ-025 With macro MCB_WR_PRBS_EN defined, mode 11 SHALL drive every lane from a 32-bit Fibonacci LFSR (x^32+x^22+x^2+x+1) that advances once per accepted beat.
REQ-026 Without MCB_WR_PRBS_EN, the LFSR SHALL not be built and mode 11 SHALL behave exactly as mode 00.

Verification
REQ-027 The bench SHALL cover these scenarios:
- Defaults, start=1, wr_rdy=1, cmd_done one cycle after cmd_en -> cmd_en rises after the 40th beat; 64 beats alternate AA../55..; second burst cmd_addr='h400; burst_cnt=1.
- wr_rdy toggling 1/0 -> exactly 64 beats per burst; wr_data holds on stalled cycles.
- cmd_done held low until 20 cycles after the last beat -> DRAIN holds, wr_en=0, cmd_addr unchanged; next burst starts the cycle after completion.
- END_ADDR=2*ADDR_INC, START_ADDR='h100 -> addresses 'h100, 'h500, 'h900, 'h100; wrap pulses once per cycle of addresses.
- rst pulsed mid-LOAD at beat 10 -> next cycle wr_en=0, cmd_addr=START_ADDR, burst_cnt=0.
- Mode 11 with MCB_WR_PRBS_EN defined -> first beat lanes = 32'h1 followed by the LFSR sequence; without the macro, output matches mode 00.
